// File: rtl/axi4_r_err_sender.sv
// axi4_r_err_sender: merges the downstream R stream toward the upstream master
// and injects SLVERR bursts for AR transactions dropped on a translation miss.
// Optional build macro AXI4_R_ERR_DECERR_EN: error beats carry DECERR instead of SLVERR.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no burst locked; grant chosen per cycle (pending drop wins)
// FWD     | forwarded burst in flight, held until its rlast handshake
// ERR     | error burst for FIFO head in flight, held until its rlast handshake
module axi4_r_err_sender #(
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int AXI_USER_WIDTH  = 4,
   parameter int DROP_FIFO_DEPTH = 4
) (
   input  logic                      axi4_aclk,
   input  logic                      axi4_arstn,
   input  logic                      drop_valid,
   output logic                      drop_ready,
   input  logic [AXI_ID_WIDTH-1:0]   drop_id,
   input  logic [7:0]                drop_len,
   input  logic [AXI_USER_WIDTH-1:0] drop_user,
   input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
   input  logic [1:0]                m_axi4_rresp,
   input  logic                      m_axi4_rlast,
   input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
   input  logic                      m_axi4_rvalid,
   output logic                      m_axi4_rready,
   output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
   output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
   output logic [1:0]                s_axi4_rresp,
   output logic                      s_axi4_rlast,
   output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
   output logic                      s_axi4_rvalid,
   input  logic                      s_axi4_rready,
   output logic                      busy
);

   localparam int PW = $clog2(DROP_FIFO_DEPTH);
   localparam int EW = AXI_ID_WIDTH + 8 + AXI_USER_WIDTH;

`ifdef AXI4_R_ERR_DECERR_EN
   localparam logic [1:0] ERR_RESP = 2'b11;
`else
   localparam logic [1:0] ERR_RESP = 2'b10;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_ERR} state_e;

   state_e              state_q, state_d;
   logic [PW:0]         wr_ptr_q, wr_ptr_d;
   logic [PW:0]         rd_ptr_q, rd_ptr_d;
   logic [7:0]          beat_cnt_q, beat_cnt_d;
   logic [EW-1:0]       mem_q [DROP_FIFO_DEPTH];

   logic                empty, full, push, sel_err, hs;
   logic [EW-1:0]       head;
   logic [AXI_ID_WIDTH-1:0]   head_id;
   logic [7:0]                head_len;
   logic [AXI_USER_WIDTH-1:0] head_user;

   // FIFO status, grant selection and the muxed R channel outputs
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      head      = mem_q[rd_ptr_q[PW-1:0]];
      head_id   = head[EW-1 -: AXI_ID_WIDTH];
      head_len  = head[AXI_USER_WIDTH +: 8];
      head_user = head[AXI_USER_WIDTH-1:0];
      sel_err   = (state_q == ST_ERR) || ((state_q == ST_IDLE) && !empty);

      drop_ready    = axi4_arstn && !full;
      push          = drop_valid && drop_ready;
      busy          = axi4_arstn && (!empty || (state_q != ST_IDLE));

      s_axi4_rid    = '0;
      s_axi4_rdata  = '0;
      s_axi4_rresp  = 2'b00;
      s_axi4_rlast  = 1'b0;
      s_axi4_ruser  = '0;
      s_axi4_rvalid = 1'b0;
      m_axi4_rready = 1'b0;
      if (axi4_arstn) begin
         if (sel_err) begin
            s_axi4_rid    = head_id;
            s_axi4_rresp  = ERR_RESP;
            s_axi4_rlast  = (beat_cnt_q == head_len);
            s_axi4_ruser  = head_user;
            s_axi4_rvalid = 1'b1;
         end else begin
            s_axi4_rid    = m_axi4_rid;
            s_axi4_rdata  = m_axi4_rdata;
            s_axi4_rresp  = m_axi4_rresp;
            s_axi4_rlast  = m_axi4_rlast;
            s_axi4_ruser  = m_axi4_ruser;
            s_axi4_rvalid = m_axi4_rvalid;
            m_axi4_rready = s_axi4_rready;
         end
      end
      hs = s_axi4_rvalid && s_axi4_rready;
   end

   // Next-state: grant lock, beat counter and FIFO pointers
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q;
      case (state_q)
         ST_IDLE: begin
            // lock as soon as a beat is shown unless it completes a burst now,
            // so a stalled beat can never be swapped for the other source
            if (s_axi4_rvalid && !(hs && s_axi4_rlast))
               state_d = sel_err ? ST_ERR : ST_FWD;
         end
         ST_FWD, ST_ERR: begin
            if (hs && s_axi4_rlast)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (hs && sel_err) begin
         if (s_axi4_rlast) begin
            beat_cnt_d = 8'd0;
            rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, 1'b1};
         end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
         end
      end
   end

   // Control registers with synchronous active-low reset
   always_ff @(posedge axi4_aclk) begin
      if (!axi4_arstn) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         beat_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Drop request storage; contents are don't-care until pointed at
   always_ff @(posedge axi4_aclk) begin
      if (push)
         mem_q[wr_ptr_q[PW-1:0]] <= {drop_id, drop_len, drop_user};
   end

endmodule

// File: tb/tb_axi4_r_err_sender.sv
// Directed bench for axi4_r_err_sender: error burst generation, forward/error
// arbitration at burst boundaries, FIFO full behaviour, 256-beat bursts and reset.
module tb_axi4_r_err_sender;

   logic        axi4_aclk = 1'b0;
   logic        axi4_arstn;
   logic        drop_valid;
   logic        drop_ready;
   logic [3:0]  drop_id;
   logic [7:0]  drop_len;
   logic [3:0]  drop_user;
   logic [3:0]  m_axi4_rid;
   logic [31:0] m_axi4_rdata;
   logic [1:0]  m_axi4_rresp;
   logic        m_axi4_rlast;
   logic [3:0]  m_axi4_ruser;
   logic        m_axi4_rvalid;
   logic        m_axi4_rready;
   logic [3:0]  s_axi4_rid;
   logic [31:0] s_axi4_rdata;
   logic [1:0]  s_axi4_rresp;
   logic        s_axi4_rlast;
   logic [3:0]  s_axi4_ruser;
   logic        s_axi4_rvalid;
   logic        s_axi4_rready;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int beats;
   int cyc;

`ifdef AXI4_R_ERR_DECERR_EN
   localparam logic [1:0] EXP_RESP = 2'b11;
`else
   localparam logic [1:0] EXP_RESP = 2'b10;
`endif

   always #5 axi4_aclk = ~axi4_aclk;

   axi4_r_err_sender #(
      .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .DROP_FIFO_DEPTH(4)
   ) dut (
      .axi4_aclk(axi4_aclk), .axi4_arstn(axi4_arstn),
      .drop_valid(drop_valid), .drop_ready(drop_ready), .drop_id(drop_id),
      .drop_len(drop_len), .drop_user(drop_user),
      .m_axi4_rid(m_axi4_rid), .m_axi4_rdata(m_axi4_rdata), .m_axi4_rresp(m_axi4_rresp),
      .m_axi4_rlast(m_axi4_rlast), .m_axi4_ruser(m_axi4_ruser), .m_axi4_rvalid(m_axi4_rvalid),
      .m_axi4_rready(m_axi4_rready),
      .s_axi4_rid(s_axi4_rid), .s_axi4_rdata(s_axi4_rdata), .s_axi4_rresp(s_axi4_rresp),
      .s_axi4_rlast(s_axi4_rlast), .s_axi4_ruser(s_axi4_ruser), .s_axi4_rvalid(s_axi4_rvalid),
      .s_axi4_rready(s_axi4_rready), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // inputs change 1 time unit after the rising edge, checks 1 unit later
   task automatic tick();
      @(posedge axi4_aclk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_err_beat(input string tag, input logic [3:0] id, input logic [3:0] user,
                                 input logic last);
      check({tag, "_rvalid"}, 64'(s_axi4_rvalid), 64'd1);
      check({tag, "_rid"},    64'(s_axi4_rid),    64'(id));
      check({tag, "_ruser"},  64'(s_axi4_ruser),  64'(user));
      check({tag, "_rdata"},  64'(s_axi4_rdata),  64'd0);
      check({tag, "_rresp"},  64'(s_axi4_rresp),  64'(EXP_RESP));
      check({tag, "_rlast"},  64'(s_axi4_rlast),  64'(last));
      check({tag, "_mready"}, 64'(m_axi4_rready), 64'd0);
   endtask

   initial begin
      axi4_arstn    = 1'b0;
      drop_valid    = 1'b1;
      drop_id       = 4'd1;
      drop_len      = 8'd0;
      drop_user     = 4'd1;
      m_axi4_rid    = 4'd1;
      m_axi4_rdata  = 32'h1234;
      m_axi4_rresp  = 2'b00;
      m_axi4_rlast  = 1'b1;
      m_axi4_ruser  = 4'd0;
      m_axi4_rvalid = 1'b1;
      s_axi4_rready = 1'b1;

      // reset: outputs forced low regardless of inputs
      repeat (3) tick();
      settle();
      check("rst_rvalid", 64'(s_axi4_rvalid), 64'd0);
      check("rst_mready", 64'(m_axi4_rready), 64'd0);
      check("rst_dready", 64'(drop_ready),    64'd0);
      check("rst_busy",   64'(busy),          64'd0);
      check("rst_rdata",  64'(s_axi4_rdata),  64'd0);
      drop_valid    = 1'b0;
      m_axi4_rvalid = 1'b0;
      m_axi4_rlast  = 1'b0;
      tick();
      axi4_arstn = 1'b1;
      tick();

      // single drop id=3 len=3 user=5
      drop_valid = 1'b1; drop_id = 4'd3; drop_len = 8'd3; drop_user = 4'd5;
      settle();
      check("t1_dready", 64'(drop_ready),    64'd1);
      check("t1_idle_v", 64'(s_axi4_rvalid), 64'd0);
      tick();
      drop_valid = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         settle();
         check_err_beat($sformatf("t1_b%0d", b), 4'd3, 4'd5, b == 4);
         tick();
      end
      settle();
      check("t1_busy",   64'(busy),          64'd0);
      check("t1_rvalid", 64'(s_axi4_rvalid), 64'd0);
      tick();

      // 8-beat forwarded burst, drop arrives during beat 2
      m_axi4_rvalid = 1'b1; m_axi4_rid = 4'd7; m_axi4_ruser = 4'd9; m_axi4_rresp = 2'b00;
      drop_id = 4'd2; drop_len = 8'd1; drop_user = 4'd3;
      for (int b = 0; b < 8; b++) begin
         m_axi4_rdata = 32'(100 + b);
         m_axi4_rlast = (b == 7);
         drop_valid   = (b == 1);
         settle();
         check($sformatf("t2_f%0d_rdata", b), 64'(s_axi4_rdata), 64'(100 + b));
         check($sformatf("t2_f%0d_rid", b),   64'(s_axi4_rid),   64'd7);
         check($sformatf("t2_f%0d_rlast", b), 64'(s_axi4_rlast), 64'(b == 7));
         check($sformatf("t2_f%0d_mready", b), 64'(m_axi4_rready), 64'd1);
         tick();
      end
      drop_valid   = 1'b0;
      m_axi4_rdata = 32'h55;
      m_axi4_rlast = 1'b1;
      for (int e = 0; e < 2; e++) begin
         settle();
         check_err_beat($sformatf("t2_e%0d", e), 4'd2, 4'd3, e == 1);
         tick();
      end
      settle();
      check("t2_fwd_rdata",  64'(s_axi4_rdata),  64'h55);
      check("t2_fwd_mready", 64'(m_axi4_rready), 64'd1);
      tick();
      m_axi4_rvalid = 1'b0;
      m_axi4_rlast  = 1'b0;
      settle();
      check("t2_busy", 64'(busy), 64'd0);
      tick();

      // stalled forwarded beat is held while a drop arrives
      m_axi4_rvalid = 1'b1; m_axi4_rid = 4'd9; m_axi4_rdata = 32'hAA; m_axi4_rlast = 1'b1;
      s_axi4_rready = 1'b0;
      settle();
      check("t3_rvalid0", 64'(s_axi4_rvalid), 64'd1);
      check("t3_rdata0",  64'(s_axi4_rdata),  64'hAA);
      tick();
      drop_valid = 1'b1; drop_id = 4'd4; drop_len = 8'd0; drop_user = 4'd1;
      settle();
      check("t3_rid1", 64'(s_axi4_rid), 64'd9);
      tick();
      drop_valid = 1'b0;
      settle();
      check("t3_rid2",   64'(s_axi4_rid),   64'd9);
      check("t3_rdata2", 64'(s_axi4_rdata), 64'hAA);
      s_axi4_rready = 1'b1;
      settle();
      check("t3_mready", 64'(m_axi4_rready), 64'd1);
      tick();
      m_axi4_rvalid = 1'b0; m_axi4_rlast = 1'b0;
      settle();
      check_err_beat("t3_e", 4'd4, 4'd1, 1'b1);
      tick();
      settle();
      check("t3_busy", 64'(busy), 64'd0);

      // fill the FIFO with upstream stalled
      s_axi4_rready = 1'b0;
      drop_len      = 8'd0;
      for (int k = 0; k < 4; k++) begin
         drop_valid = 1'b1; drop_id = 4'(k + 1); drop_user = 4'(k + 1);
         settle();
         check($sformatf("t4_dready%0d", k), 64'(drop_ready), 64'd1);
         tick();
      end
      drop_id = 4'd5; drop_user = 4'd5;
      settle();
      check("t4_full",  64'(drop_ready), 64'd0);
      check("t4_head",  64'(s_axi4_rid), 64'd1);
      tick();
      s_axi4_rready = 1'b1;
      settle();
      check("t4_full_pop", 64'(drop_ready), 64'd0);
      check_err_beat("t4_e1", 4'd1, 4'd1, 1'b1);
      tick();
      settle();
      check("t4_dready_again", 64'(drop_ready), 64'd1);
      check_err_beat("t4_e2", 4'd2, 4'd2, 1'b1);
      tick();
      drop_valid = 1'b0;
      for (int k = 3; k <= 5; k++) begin
         settle();
         check_err_beat($sformatf("t4_e%0d", k), 4'(k), 4'(k), 1'b1);
         tick();
      end
      settle();
      check("t4_busy", 64'(busy), 64'd0);

      // 256-beat error burst with random upstream stalls
      drop_valid = 1'b1; drop_id = 4'd6; drop_len = 8'd255; drop_user = 4'd10;
      tick();
      drop_valid = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < 256 && cyc < 3000) begin
         s_axi4_rready = 1'($urandom_range(0, 1));
         settle();
         if (s_axi4_rvalid && s_axi4_rready) begin
            check("t5_rid",   64'(s_axi4_rid),   64'd6);
            check("t5_rlast", 64'(s_axi4_rlast), 64'(beats == 255));
            beats++;
         end
         tick();
         cyc++;
      end
      check("t5_beats", 64'(beats), 64'd256);
      s_axi4_rready = 1'b0;
      settle();
      check("t5_busy", 64'(busy), 64'd0);
      tick();

      // reset mid-burst at beat 100
      drop_valid = 1'b1;
      tick();
      drop_valid = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < 99 && cyc < 2000) begin
         s_axi4_rready = 1'($urandom_range(0, 1));
         settle();
         if (s_axi4_rvalid && s_axi4_rready) beats++;
         tick();
         cyc++;
      end
      check("t6_beats", 64'(beats), 64'd99);
      s_axi4_rready = 1'b1;
      settle();
      check("t6_b100_rlast", 64'(s_axi4_rlast), 64'd0);
      axi4_arstn = 1'b0;
      tick();
      settle();
      check("t6_rst_rvalid", 64'(s_axi4_rvalid), 64'd0);
      check("t6_rst_busy",   64'(busy),          64'd0);
      axi4_arstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         settle();
         check($sformatf("t6_post_rvalid%0d", i), 64'(s_axi4_rvalid), 64'd0);
         check($sformatf("t6_post_busy%0d", i),   64'(busy),          64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
